// File: rtl/xoro_pkg.sv
// Shared register map for the tick timer bank: per-channel offsets, field bit
// positions and the byte-lane merge used by every writable register.
package xoro_pkg;

    localparam int CH_STRIDE   = 'h10;
    localparam int CH_SEL_LSB  = $clog2(CH_STRIDE);
    localparam int CH_SEL_MSB  = CH_SEL_LSB + 2;
    localparam int REG_SEL_LSB = 2;
    localparam int REG_SEL_MSB = 3;

    typedef enum logic [1:0] {
        REG_RELOAD = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN_BIT        = 0;
    localparam int CTRL_PERIODIC_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT    = 2;
    localparam int STATUS_EXPIRED_BIT = 0;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One timer channel: RELOAD/COUNT/CTRL/STATUS registers, down-counter and
// the one-cycle expiry tick.
module tick_channel
    import xoro_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic        tick,
    output logic        irq_req
);

    logic [CNT_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             en_q, en_d;
    logic             periodic_q, periodic_d;
    logic             irq_en_q, irq_en_d;
    logic             expired_q, expired_d;
    logic [31:0]      reload_ext;
    logic [31:0]      reload_merged;
    logic             ctrl_wr;

    assign tick    = en_q && (count_q == '0);
    assign irq_req = expired_q && irq_en_q;
    assign ctrl_wr = wr_en && (reg_sel == REG_CTRL) && wstrb[0];

    always_comb begin
        reload_d   = reload_q;
        count_d    = count_q;
        en_d       = en_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        expired_d  = expired_q;

        reload_ext               = '0;
        reload_ext[CNT_W-1:0]    = reload_q;
        reload_merged            = merge_lanes(reload_ext, wdata, wstrb);

        if (en_q) begin
            if (count_q != '0)   count_d = count_q - CNT_W'(1);
            else if (periodic_q) count_d = reload_q;
            else                 en_d    = 1'b0;
        end

        // Clear first so a same-cycle expiry overrides it.
        if (wr_en && (reg_sel == REG_STATUS) && wstrb[0] && wdata[STATUS_EXPIRED_BIT])
            expired_d = 1'b0;
        if (tick)
            expired_d = 1'b1;

        if (wr_en && (reg_sel == REG_RELOAD))
            reload_d = reload_merged[CNT_W-1:0];

        if (ctrl_wr) begin
            en_d       = wdata[CTRL_EN_BIT];
            periodic_d = wdata[CTRL_PERIODIC_BIT];
            irq_en_d   = wdata[CTRL_IRQ_EN_BIT];
            if (wdata[CTRL_EN_BIT] && !en_q) count_d = reload_q;
            else if (!wdata[CTRL_EN_BIT])    count_d = count_q;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_RELOAD: rd_data[CNT_W-1:0] = reload_q;
            REG_COUNT:  rd_data[CNT_W-1:0] = count_q;
            REG_CTRL: begin
                rd_data[CTRL_EN_BIT]       = en_q;
                rd_data[CTRL_PERIODIC_BIT] = periodic_q;
                rd_data[CTRL_IRQ_EN_BIT]   = irq_en_q;
            end
            default:    rd_data[STATUS_EXPIRED_BIT] = expired_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_q   <= '0;
            count_q    <= '0;
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            reload_q   <= reload_d;
            count_q    <= count_d;
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            expired_q  <= expired_d;
        end
    end

endmodule

// File: rtl/tick_timer_bank.sv
// Bank of NUM_CH tick timers on a picorv32-style memory bus: address decode,
// one-cycle registered response and interrupt reduction.
module tick_timer_bank
    import xoro_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [NUM_CH-1:0] tick,
    output logic              irq
);

    logic              mem_ready_q, mem_ready_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              req;
    logic              is_write;
    logic [2:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [31:0]       sel_rdata;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] ch_irq;
    logic              unused_bus_bits;

    assign req      = mem_valid && enable && !mem_ready_q;
    assign is_write = |mem_wstrb;
    assign ch_sel   = mem_addr[CH_SEL_MSB:CH_SEL_LSB];
    assign reg_sel  = mem_addr[REG_SEL_MSB:REG_SEL_LSB];

    assign unused_bus_bits = ^{mem_instr, mem_addr[31:CH_SEL_MSB+1], mem_addr[REG_SEL_LSB-1:0]};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_wr[g] = req && is_write && (ch_sel == 3'(g));

        tick_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (ch_wr[g]),
            .reg_sel (reg_sel),
            .wstrb   (mem_wstrb),
            .wdata   (mem_wdata),
            .rd_data (ch_rdata[g]),
            .tick    (tick[g]),
            .irq_req (ch_irq[g])
        );
    end

    // Channels beyond NUM_CH never match and so read as zero.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 3'(i)) sel_rdata = ch_rdata[i];
        end
        mem_ready_d = req;
        mem_rdata_d = (req && !is_write) ? sel_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign irq       = |ch_irq;

endmodule

// File: doc/tick_timer_bank.md
TICK_TIMER_BANK -- requirements
Module: tick_timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (legal 1..8).
REQ-002 Parameter CNT_W, default 32, counter and reload width in bits (legal 8..32).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  region select from busInterface; the block responds only when high.
REQ-006 mem_valid  input  1  picorv32 bus request.
REQ-007 mem_instr  input  1  instruction-fetch flag; ignored.
REQ-008 mem_addr  input  32  byte address; bits [6:4] select the channel, bits [3:2] select the register.
REQ-009 mem_wstrb  input  4  byte write strobes; all zero means a read.
REQ-010 mem_wdata  input  32  write data.
REQ-011 mem_ready  output  1  transfer-complete pulse.
REQ-012 mem_rdata  output  32  read data, valid while mem_ready is high.
REQ-013 tick  output  NUM_CH  per-channel one-cycle expiry pulse.
REQ-014 irq  output  1  level interrupt: OR over channels of (expired AND irq_en).

Function
REQ-015 Per-channel register map at stride 0x10: +0x0 RELOAD (RW), +0x4 COUNT (RO), +0x8 CTRL (RW: bit0 en, bit1 periodic, bit2 irq_en), +0xC STATUS (bit0 expired; write 1 to clear).
REQ-016 Handshake: mem_ready SHALL assert exactly one cycle after a cycle in which mem_valid, enable and !mem_ready are all high; it SHALL be high for one cycle only.
REQ-017 A write SHALL update only the byte lanes whose mem_wstrb bit is set; bits above CNT_W and undefined CTRL bits are ignored on write and read as 0.
REQ-018 A read SHALL return the register value as sampled in the request cycle.
REQ-019 A channel index >= NUM_CH SHALL read 0, ignore writes, and still complete with mem_ready.
REQ-020 Writes to COUNT SHALL be ignored.
REQ-021 A CTRL write that changes en from 0 to 1 SHALL load COUNT with RELOAD on the following cycle; writing en=1 while en is already 1 SHALL NOT reload.
REQ-022 While en=1 and COUNT!=0, COUNT SHALL decrement by 1 per cycle.
REQ-023 While en=1 and COUNT==0: tick[ch] SHALL pulse for that cycle and expired SHALL set. If periodic=1, COUNT SHALL reload from RELOAD, giving a period of RELOAD+1 cycles. If periodic=0, en SHALL clear and COUNT SHALL hold at 0.
REQ-024 RELOAD=0 with periodic=1 SHALL produce a tick every cycle.
REQ-025 A RELOAD write while a channel is running SHALL take effect only at the next reload.
REQ-026 When a STATUS write-1-to-clear and a new expiry occur in the same cycle, the expiry wins and expired stays 1.
REQ-027 A CTRL write clearing en SHALL freeze COUNT at its current value; tick SHALL be 0 from the next cycle.
REQ-028 Counting SHALL continue regardless of bus activity; bus accesses SHALL add no stall cycles.
REQ-029 irq SHALL be combinational from the expired and irq_en register bits only, with no glitch path from the bus.

Reset
REQ-030 While reset is high: RELOAD, COUNT, CTRL, STATUS = 0; mem_ready = 0; mem_rdata = 0; tick = 0; irq = 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer. No mem_ready SHALL be issued for that request after reset deasserts.

Structure
REQ-032 Register offsets, CTRL/STATUS bit indices and the channel stride SHALL live in the shared package xoro_pkg.
REQ-033 One sub-module, tick_channel, SHALL hold one channel's counter, registers and tick logic, instantiated NUM_CH times by generate.
REQ-034 The top module SHALL contain only address decode, the mem_ready/mem_rdata pipeline register and the irq reduction.

Verification
REQ-035 Periodic: ch0 RELOAD=4, CTRL=0x3 -> tick[0] pulses every 5 cycles; COUNT reads cycle 4,3,2,1,0.
REQ-036 One-shot with irq: ch2 RELOAD=9, CTRL=0x5 -> a single tick[2] 10 cycles after COUNT is loaded; irq goes to 1, CTRL.en reads 0, COUNT reads 0; a STATUS write of 0x1 drops irq.
REQ-037 Clear/expiry collision: ch1 RELOAD=0, CTRL=0x7, then STATUS write 0x1 -> expired still reads 1 and irq stays 1.
REQ-038 Byte strobes: RELOAD=0xFFFFFFFF, then write 0x00000012 with mem_wstrb=0001 -> RELOAD reads 0xFFFFFF12.
REQ-039 Unmapped channel and reset: read channel 6 with NUM_CH=4 -> mem_ready after 1 cycle, rdata 0; separately, assert reset during a pending read -> no mem_ready, all registers read 0 afterwards.
REQ-040 Live reload change: periodic ch3 running with RELOAD=7, RELOAD rewritten to 2 -> the current period stays 8 cycles, then subsequent periods are 3 cycles.
